ru_wb_arbiter: RTL and testbench
================================

# ru_wb_arbiter

Register-unit (RU) write-port arbiter for the pipelined/multicycle CPU. It shares the single RU write port between two requesters. The execute path writes either an ALU result or PC+4 (link). The load path returns data-memory read data with variable latency. Each cycle it grants at most one requester, registers the winning write, and drives the 2-bit writeback source code (00 ALU, 01 data memory, 10 PC+4) alongside the selected data.

## Interface
- STREAK_MAX, 4, consecutive load grants allowed while execute waits before execute is forced through; legal range 1..15
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- exe_valid  in  1  execute write request
- exe_ready  out  1  execute request accepted this cycle
- exe_rd  in  5  execute destination register
- exe_link  in  1  1 = write exe_pc4 (src 10), 0 = write exe_alu (src 00)
- exe_pc4  in  32  PC+4 value
- exe_alu  in  32  ALU result
- ld_valid  in  1  load-return write request
- ld_ready  out  1  load request accepted this cycle
- ld_rd  in  5  load destination register
- ld_data  in  32  data-memory read data
- ru_we  out  1  RU write enable, one-cycle pulse per accepted request
- ru_rd  out  5  RU write address
- ru_wdata  out  32  RU write data
- ru_src  out  2  writeback source code of the current write: 00 ALU, 01 mem, 10 PC+4

## Operation
- Handshake: a transfer occurs when valid & ready. Once raised, valid and its payload stay stable until accepted. ready is combinational from both valids. Requesters must not derive valid from ready.
- At most one of exe_ready / ld_ready is high in any cycle. ready is never high without the matching valid.
- FSM states:
  - LD_PRI (reset state): load wins if ld_valid; otherwise execute wins if exe_valid.
  - EXE_TURN: execute wins if exe_valid; otherwise load wins if ld_valid.
- Streak counter (4 bits, reset 0):
  - increments on each load grant while exe_valid is high;
  - clears on any execute grant, and on any cycle with exe_valid low.
- LD_PRI -> EXE_TURN when a load grant brings the counter to STREAK_MAX.
- EXE_TURN -> LD_PRI after one execute grant, or if exe_valid is low. The counter clears on this transition.
- On a grant, the output register loads in the next cycle:
  - load: ru_we=1, ru_rd=ld_rd, ru_wdata=ld_data, ru_src=01
  - execute: ru_we=1, ru_rd=exe_rd, ru_src = exe_link ? 10 : 00, ru_wdata = exe_link ? exe_pc4 : exe_alu
- No grant: ru_we=0. ru_rd, ru_wdata and ru_src hold their last values.
- Same rd from both requesters in one cycle: no merging. The RU sees two writes, in grant order.

## Timing
- Reset (synchronous): ru_we=0, ru_rd=0, ru_wdata=0, ru_src=00, state=LD_PRI, counter=0. rst has priority over any transfer in the same edge; a request in flight during reset is not accepted.
- Latency: 1 cycle from handshake edge to ru_we high. Throughput: 1 write per cycle.
- Load-only or execute-only traffic: accepted every cycle, zero stall.
- Both valid continuously: STREAK_MAX load grants, then 1 execute grant, repeating.
- ready outputs are combinational. Every other output is registered.

## Configuration
- RUWB_X0_FILTER_EN defined:
  - an accepted request with rd==0 completes its handshake normally, but the next cycle shows ru_we=0;
  - ru_rd, ru_wdata and ru_src still update;
  - arbitration and counter are unaffected.
- Undefined: rd==0 writes pulse ru_we=1 like any other; the RU is responsible for discarding x0 writes.

## Test plan
- Reset: assert rst 2 cycles with both valids high -> both readies 0, ru_we=0, ru_src=00, ru_wdata=0 throughout.
- Execute only:
  - exe_valid=1, exe_rd=5, exe_link=0, exe_alu=0x0000_002A -> exe_ready=1 same cycle; next cycle ru_we=1, ru_rd=5, ru_wdata=0x2A, ru_src=00.
  - Repeat with exe_link=1, exe_pc4=0x0000_0104 -> ru_src=10, ru_wdata=0x104.
- Load only: ld_valid=1, ld_rd=7, ld_data=0xDEAD_BEEF -> ld_ready=1; next cycle ru_we=1, ru_rd=7, ru_wdata=0xDEADBEEF, ru_src=01.
- Contention, STREAK_MAX=4: both valid for 10 cycles (new payload per grant) -> grant sequence L,L,L,L,E,L,L,L,L,E. exe_ready is never high on a load-grant cycle.
- Streak reset: 3 load grants with exe_valid=1, drop exe_valid 1 cycle, raise again -> counter restarts; 4 more load grants precede the execute grant.
- x0 write, exe_rd=0, exe_alu=0x1:
  - with RUWB_X0_FILTER_EN: exe_ready=1, next cycle ru_we=0, ru_wdata=0x1;
  - without it: ru_we=1.

Source files
------------

// File: rtl/ru_wb_arbiter.sv
// Shares the RU write port between execute and load-return requesters; ready is combinational, write lands 1 cycle after handshake.
// Optional RUWB_X0_FILTER_EN suppresses ru_we for rd==0 writes while keeping arbitration unchanged.
module ru_wb_arbiter #(
   parameter int unsigned STREAK_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        exe_valid,
   output logic        exe_ready,
   input  logic [4:0]  exe_rd,
   input  logic        exe_link,
   input  logic [31:0] exe_pc4,
   input  logic [31:0] exe_alu,
   input  logic        ld_valid,
   output logic        ld_ready,
   input  logic [4:0]  ld_rd,
   input  logic [31:0] ld_data,
   output logic        ru_we,
   output logic [4:0]  ru_rd,
   output logic [31:0] ru_wdata,
   output logic [1:0]  ru_src
);

   typedef enum logic [0:0] {LD_PRI, EXE_TURN} state_t;

   localparam logic [3:0] STREAK_LIM = 4'(STREAK_MAX);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        exe_gnt, ld_gnt;
   logic        we_d;
   logic        ru_we_q;
   logic [4:0]  ru_rd_q, rd_d;
   logic [31:0] ru_wdata_q, wdata_d;
   logic [1:0]  ru_src_q, src_d;

   always_comb begin
      exe_gnt = 1'b0;
      ld_gnt  = 1'b0;
      state_d = state_q;
      cnt_d   = cnt_q;

      // Nothing is accepted while reset is asserted.
      if (!rst) begin
         case (state_q)
            LD_PRI: begin
               ld_gnt  = ld_valid;
               exe_gnt = exe_valid & ~ld_valid;
            end
            EXE_TURN: begin
               exe_gnt = exe_valid;
               ld_gnt  = ld_valid & ~exe_valid;
            end
            default: ;
         endcase
      end

      if (exe_gnt || !exe_valid) begin
         cnt_d = 4'd0;
      end else if (ld_gnt) begin
         cnt_d = cnt_q + 4'd1;
      end

      case (state_q)
         LD_PRI: begin
            if (ld_gnt && exe_valid && (cnt_q + 4'd1 == STREAK_LIM)) begin
               state_d = EXE_TURN;
            end
         end
         EXE_TURN: begin
            if (exe_gnt || !exe_valid) begin
               state_d = LD_PRI;
               cnt_d   = 4'd0;
            end
         end
         default: state_d = LD_PRI;
      endcase
   end

   always_comb begin
      rd_d    = ld_rd;
      wdata_d = ld_data;
      src_d   = 2'b01;
      if (exe_gnt) begin
         rd_d    = exe_rd;
         wdata_d = exe_link ? exe_pc4 : exe_alu;
         src_d   = exe_link ? 2'b10 : 2'b00;
      end
`ifdef RUWB_X0_FILTER_EN
      we_d = (exe_gnt | ld_gnt) & (rd_d != 5'd0);
`else
      we_d = exe_gnt | ld_gnt;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= LD_PRI;
         cnt_q      <= 4'd0;
         ru_we_q    <= 1'b0;
         ru_rd_q    <= 5'd0;
         ru_wdata_q <= 32'd0;
         ru_src_q   <= 2'b00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ru_we_q <= we_d;
         // Payload holds its last value on idle cycles.
         if (exe_gnt || ld_gnt) begin
            ru_rd_q    <= rd_d;
            ru_wdata_q <= wdata_d;
            ru_src_q   <= src_d;
         end
      end
   end

   assign exe_ready = exe_gnt;
   assign ld_ready  = ld_gnt;
   assign ru_we     = ru_we_q;
   assign ru_rd     = ru_rd_q;
   assign ru_wdata  = ru_wdata_q;
   assign ru_src    = ru_src_q;

endmodule

// File: tb/tb_ru_wb_arbiter.sv
// Directed bench for ru_wb_arbiter with a queue-based scoreboard and an independent output monitor.
module tb_ru_wb_arbiter;

   typedef struct packed {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] data;
      logic [1:0]  src;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        exe_valid, exe_ready, exe_link;
   logic [4:0]  exe_rd;
   logic [31:0] exe_pc4, exe_alu;
   logic        ld_valid, ld_ready;
   logic [4:0]  ld_rd;
   logic [31:0] ld_data;
   logic        ru_we;
   logic [4:0]  ru_rd;
   logic [31:0] ru_wdata;
   logic [1:0]  ru_src;

   int n_vec = 0;
   int n_bad = 0;
   bit mon_en = 1'b0;
   wr_t expq[$];
   logic [4:0]  hold_rd    = 5'd0;
   logic [31:0] hold_wdata = 32'd0;
   logic [1:0]  hold_src   = 2'b00;

   ru_wb_arbiter #(.STREAK_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .exe_valid(exe_valid), .exe_ready(exe_ready), .exe_rd(exe_rd),
      .exe_link(exe_link), .exe_pc4(exe_pc4), .exe_alu(exe_alu),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
      .ru_we(ru_we), .ru_rd(ru_rd), .ru_wdata(ru_wdata), .ru_src(ru_src)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", nm, $time, act, exp);
      end
   endtask

   function automatic logic exp_we(input logic [4:0] rd);
`ifdef RUWB_X0_FILTER_EN
      return rd != 5'd0;
`else
      return 1'b1;
`endif
   endfunction

   // One clock: check readies against the expected grant, record the write it implies.
   task automatic cycle(input byte g);
      wr_t e;
      #7;
      chk("exe_ready", {31'd0, exe_ready}, {31'd0, g == "E"});
      chk("ld_ready",  {31'd0, ld_ready},  {31'd0, g == "L"});
      if (g == "L") begin
         e = '{we: exp_we(ld_rd), rd: ld_rd, data: ld_data, src: 2'b01};
         expq.push_back(e);
      end else if (g == "E") begin
         e = '{we: exp_we(exe_rd), rd: exe_rd,
               data: exe_link ? exe_pc4 : exe_alu, src: exe_link ? 2'b10 : 2'b00};
         expq.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic new_ld(input int n);
      ld_rd   = 5'(n % 31 + 1);
      ld_data = 32'h1000_0000 + 32'(n);
   endtask

   task automatic new_exe(input int n);
      exe_rd   = 5'(n % 29 + 2);
      exe_link = n[0];
      exe_alu  = 32'h2000_0000 + 32'(n);
      exe_pc4  = 32'h3000_0000 + 32'(n);
   endtask

   always @(negedge clk) begin
      wr_t e;
      if (mon_en) begin
         if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("ru_we", {31'd0, ru_we}, {31'd0, e.we});
            hold_rd    = e.rd;
            hold_wdata = e.data;
            hold_src   = e.src;
         end else begin
            chk("ru_we_idle", {31'd0, ru_we}, 32'd0);
         end
         chk("ru_rd",    {27'd0, ru_rd},  {27'd0, hold_rd});
         chk("ru_wdata", ru_wdata,         hold_wdata);
         chk("ru_src",   {30'd0, ru_src}, {30'd0, hold_src});
      end
   end

   initial begin
      string seq;
      int    n;
      rst = 1'b1;
      exe_valid = 1'b1; ld_valid = 1'b1;
      exe_rd = 5'd3; exe_link = 1'b0; exe_alu = 32'h55; exe_pc4 = 32'h66;
      ld_rd = 5'd4; ld_data = 32'h77;
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      cycle("-");
      cycle("-");
      rst = 1'b0; exe_valid = 1'b0; ld_valid = 1'b0;
      cycle("-");

      // Execute only: ALU then link.
      exe_valid = 1'b1; exe_rd = 5'd5; exe_link = 1'b0; exe_alu = 32'h0000_002A;
      cycle("E");
      exe_link = 1'b1; exe_pc4 = 32'h0000_0104;
      cycle("E");
      exe_valid = 1'b0;
      cycle("-");

      // Load only.
      ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'hDEAD_BEEF;
      cycle("L");
      ld_valid = 1'b0;
      cycle("-");

      // Contention: both valid for 10 cycles.
      n = 100;
      new_ld(n); new_exe(n);
      exe_valid = 1'b1; ld_valid = 1'b1;
      seq = "LLLLELLLLE";
      for (int i = 0; i < seq.len(); i++) begin
         cycle(seq[i]);
         n++;
         if (seq[i] == "L") new_ld(n);
         else new_exe(n);
      end
      exe_valid = 1'b0; ld_valid = 1'b0;
      cycle("-");

      // Streak restart after exe_valid drops for a cycle.
      exe_valid = 1'b1; ld_valid = 1'b1;
      seq = "LLL";
      for (int i = 0; i < seq.len(); i++) begin
         cycle(seq[i]);
         n++;
         new_ld(n);
      end
      exe_valid = 1'b0;
      cycle("L");
      n++;
      new_ld(n);
      exe_valid = 1'b1;
      seq = "LLLLE";
      for (int i = 0; i < seq.len(); i++) begin
         cycle(seq[i]);
         n++;
         if (seq[i] == "L") new_ld(n);
         else new_exe(n);
      end
      exe_valid = 1'b0; ld_valid = 1'b0;
      cycle("-");

      // x0 write.
      exe_valid = 1'b1; exe_rd = 5'd0; exe_link = 1'b0; exe_alu = 32'h0000_0001;
      cycle("E");
      exe_valid = 1'b0;
      cycle("-");
      cycle("-");

      chk("queue_drained", 32'(expq.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
